// File: rtl/io_dispatch_if.sv
// CPU request handshake plus peripheral bus signals for io_dispatch.
// The master modport is the requester/bus-status side; slave is the dispatcher.
interface io_dispatch_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_device;
  logic [5:0]  req_command;
  logic [31:0] req_data;
  logic        bus_busy;
  logic [4:0]  device;
  logic [5:0]  command;
  logic [31:0] data_out;
  logic [15:0] issue_count;

  modport master (
    output req_valid, req_device, req_command, req_data, bus_busy,
    input  req_ready, device, command, data_out, issue_count
  );

  modport slave (
    input  req_valid, req_device, req_command, req_data, bus_busy,
    output req_ready, device, command, data_out, issue_count
  );
endinterface

// File: rtl/io_dispatch.sv
// Queues CPU I/O requests in a small FIFO and issues them one per cycle onto the
// peripheral bus whenever the bus is free; no-op requests are dropped at the door.
module io_dispatch #(
  parameter int unsigned DEPTH = 4
) (
  input logic          clk,
  input logic          reset,
  io_dispatch_if.slave bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  localparam logic [4:0]  IdleDevice  = 5'b11111;
  localparam logic [5:0]  IdleCommand = 6'b000000;

  // Entry layout: {device, command, data}
  logic [42:0]     r_mem [DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic [4:0]      r_device;
  logic [5:0]      r_command;
  logic [31:0]     r_data;
  logic [15:0]     r_issue_count;

  logic            w_ready;
  logic            w_push;
  logic            w_pop;
  logic [42:0]     w_head;

  // Readiness uses registered occupancy only, so a same-cycle pop never frees a full slot.
  assign w_ready = !reset && (r_count < Full);
  assign w_push  = bus.req_valid && w_ready && (bus.req_command != IdleCommand);
  assign w_pop   = (r_count != '0) && !bus.bus_busy;
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.req_device, bus.req_command, bus.req_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_device      <= IdleDevice;
      r_command     <= IdleCommand;
      r_data        <= '0;
      r_issue_count <= '0;
    end else if (w_pop) begin
      r_device      <= w_head[42:38];
      r_command     <= w_head[37:32];
      r_data        <= w_head[31:0];
      r_issue_count <= r_issue_count + 16'd1;
    end else begin
      r_device      <= IdleDevice;
      r_command     <= IdleCommand;
      r_data        <= '0;
    end
  end

  assign bus.req_ready   = w_ready;
  assign bus.device      = r_device;
  assign bus.command     = r_command;
  assign bus.data_out    = r_data;
  assign bus.issue_count = r_issue_count;

endmodule
